bch15_7_serial_decoder: RTL



---
 rtl/bch15_7_serial_decoder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/bch15_7_serial_decoder.sv
// Bit-serial BCH(15,7,t=2) decoder: syndromes, one-cycle locator solve, 15-cycle Chien search.
// Optional `BCH_DEC_STATS_EN adds saturating corrected/failed word counters (stat_corr, stat_fail).
`timescale 1ns/1ps
module bch15_7_serial_decoder #(
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_msg,
  output logic [1:0] out_err_cnt,
  output logic       out_uncorr
`ifdef BCH_DEC_STATS_EN
  ,
  output logic [15:0] stat_corr,
  output logic [15:0] stat_fail
`endif
);

  localparam logic [1:0] ST_SHIFT = 2'd0;
  localparam logic [1:0] ST_SOLVE = 2'd1;
  localparam logic [1:0] ST_CHIEN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // GF(16) helpers, field polynomial x^4+x+1
  function automatic logic [3:0] gf_mul_a(input logic [3:0] x);
    return {x[2], x[1], x[0] ^ x[3], x[3]};
  endfunction

  function automatic logic [3:0] gf_mul_a3(input logic [3:0] x);
    return gf_mul_a(gf_mul_a(gf_mul_a(x)));
  endfunction

  function automatic logic [3:0] gf_mul_ainv(input logic [3:0] x);
    return {x[0], x[3], x[2], x[1] ^ x[0]};
  endfunction

  function automatic logic [3:0] gf_sq(input logic [3:0] x);
    return {x[3], x[3] ^ x[1], x[2], x[2] ^ x[0]};
  endfunction

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'd0;
    sh  = a;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = gf_mul_a(sh);
    end
    return acc;
  endfunction

  function automatic logic [3:0] gf_inv(input logic [3:0] x);
    case (x)
      4'h1: return 4'h1;  4'h2: return 4'h9;  4'h3: return 4'he;  4'h4: return 4'hd;
      4'h5: return 4'hb;  4'h6: return 4'h7;  4'h7: return 4'h6;  4'h8: return 4'hf;
      4'h9: return 4'h2;  4'ha: return 4'hc;  4'hb: return 4'h5;  4'hc: return 4'ha;
      4'hd: return 4'h4;  4'he: return 4'h3;  4'hf: return 4'h8;  default: return 4'h0;
    endcase
  endfunction

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_s1, r_s3, r_p1, r_p3;
  logic [3:0]  r_t1, r_t2;
  logic [14:0] r_raw, r_mask;
  logic [1:0]  r_exp, r_roots;
  logic        r_out_valid, r_out_uncorr;
  logic [6:0]  r_out_msg;
  logic [1:0]  r_out_err_cnt;

  logic [3:0]  w_s1_nxt, w_s3_nxt, w_sig2, w_eval;
  logic [14:0] w_raw_nxt;
  logic [1:0]  w_exp;
  logic        w_hs;

  always_comb begin
    w_s1_nxt  = 4'd0;
    w_s3_nxt  = 4'd0;
    w_raw_nxt = 15'd0;
    if (MSB_FIRST != 0) begin
      w_s1_nxt  = gf_mul_a(r_s1) ^ {3'b000, in_bit};
      w_s3_nxt  = gf_mul_a3(r_s3) ^ {3'b000, in_bit};
      w_raw_nxt = {r_raw[13:0], in_bit};
    end else begin
      w_s1_nxt  = r_s1 ^ (in_bit ? r_p1 : 4'd0);
      w_s3_nxt  = r_s3 ^ (in_bit ? r_p3 : 4'd0);
      w_raw_nxt = {in_bit, r_raw[14:1]};
    end
  end

  // sigma2 = (S3 + S1^3)/S1 = S3*S1^-1 + S1^2; inv(0)=0 yields sigma2=0 when S1=0
  always_comb begin
    w_sig2 = gf_mul(r_s3, gf_inv(r_s1)) ^ gf_sq(r_s1);
    w_exp  = 2'd2;
    if (r_s1 == 4'd0 && r_s3 == 4'd0) w_exp = 2'd0;
    else if (r_s1 == 4'd0)            w_exp = 2'd3;
    else if (w_sig2 == 4'd0)          w_exp = 2'd1;
  end

  assign w_eval = 4'd1 ^ r_t1 ^ r_t2;
  assign w_hs   = (r_state == ST_OUT) && r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_SHIFT;
      r_cnt         <= 4'd0;
      r_s1          <= 4'd0;
      r_s3          <= 4'd0;
      r_p1          <= 4'd1;
      r_p3          <= 4'd1;
      r_t1          <= 4'd0;
      r_t2          <= 4'd0;
      r_raw         <= 15'd0;
      r_mask        <= 15'd0;
      r_exp         <= 2'd0;
      r_roots       <= 2'd0;
      r_out_valid   <= 1'b0;
      r_out_msg     <= 7'd0;
      r_out_err_cnt <= 2'd0;
      r_out_uncorr  <= 1'b0;
    end else begin
      case (r_state)
        ST_SHIFT: if (in_valid) begin
          r_s1  <= w_s1_nxt;
          r_s3  <= w_s3_nxt;
          r_p1  <= gf_mul_a(r_p1);
          r_p3  <= gf_mul_a3(r_p3);
          r_raw <= w_raw_nxt;
          if (r_cnt == 4'd14) begin
            r_cnt   <= 4'd0;
            r_state <= ST_SOLVE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_SOLVE: begin
          r_t1    <= r_s1;
          r_t2    <= w_sig2;
          r_exp   <= w_exp;
          r_roots <= 2'd0;
          r_mask  <= 15'd0;
          r_state <= ST_CHIEN;
        end
        ST_CHIEN: begin
          if (w_eval == 4'd0) begin
            r_mask[r_cnt] <= 1'b1;
            if (r_roots != 2'd3) r_roots <= r_roots + 2'd1;
          end
          r_t1 <= gf_mul_ainv(r_t1);
          r_t2 <= gf_mul_ainv(gf_mul_ainv(r_t2));
          if (r_cnt == 4'd14) begin
            r_cnt   <= 4'd0;
            r_state <= ST_OUT;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          // First OUT cycle registers the verdict; outputs then hold until accepted
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            if (r_roots == r_exp) begin
              r_out_msg     <= r_raw[14:8] ^ r_mask[14:8];
              r_out_err_cnt <= r_roots;
              r_out_uncorr  <= 1'b0;
            end else begin
              r_out_msg     <= r_raw[14:8];
              r_out_err_cnt <= 2'd0;
              r_out_uncorr  <= 1'b1;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_s1        <= 4'd0;
            r_s3        <= 4'd0;
            r_p1        <= 4'd1;
            r_p3        <= 4'd1;
            r_cnt       <= 4'd0;
            r_mask      <= 15'd0;
            r_state     <= ST_SHIFT;
          end
        end
      endcase
    end
  end

  assign in_ready    = (r_state == ST_SHIFT);
  assign out_valid   = r_out_valid;
  assign out_msg     = r_out_msg;
  assign out_err_cnt = r_out_err_cnt;
  assign out_uncorr  = r_out_uncorr;

`ifdef BCH_DEC_STATS_EN
  logic [15:0] r_stat_corr, r_stat_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_corr <= 16'd0;
      r_stat_fail <= 16'd0;
    end else if (w_hs) begin
      if (r_out_err_cnt != 2'd0 && r_stat_corr != 16'hFFFF) r_stat_corr <= r_stat_corr + 16'd1;
      if (r_out_uncorr && r_stat_fail != 16'hFFFF)          r_stat_fail <= r_stat_fail + 16'd1;
    end
  end

  assign stat_corr = r_stat_corr;
  assign stat_fail = r_stat_fail;
`endif

endmodule
